pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the in-order core.
- Merges per-stage stall requests into a thermometer stall vector and inserts a bubble below the highest stalled boundary.
- Sequences multi-cycle-op stalls with an internal down-counter.
- Arbitrates trap and jump redirects, holding a redirect pending while a downstream stall blocks it.
- Sits beside the pipeline registers and drives PC, IF_ID, ID_EX, EX_MEM and MEM_WB stall, flush and PC-load controls.

Parameters:
- NUM_STAGES, 6: pipeline boundaries; bit 0 = PC, ascending downstream.
- ADDR_WIDTH, 32: PC width.
- CNT_WIDTH, 6: multi-cycle count width.
- JUMP_STAGE, 2: boundary index owning the jump; a jump flushes boundaries 1..JUMP_STAGE.
- TRAP_STAGE, 3: boundary index owning the trap; a trap flushes boundaries 1..TRAP_STAGE. Must satisfy TRAP_STAGE ≥ JUMP_STAGE.
- MC_STAGE, 3: highest boundary stalled while a multi-cycle op runs.
- PERF_WIDTH, 32: stall perf counter width.

Ports:
- clk_in, in, 1: clock.
- reset_in, in, 1: asynchronous reset, active-high.
- stall_req_in, in, NUM_STAGES: bit k = request to hold boundaries 0..k. Bit 2 is the ID load hazard.
- mc_start_in, in, 1: multi-cycle op start pulse.
- mc_cycles_in, in, CNT_WIDTH: extra stall cycles for that op.
- jump_enable_in, in, 1: jump request.
- jump_address_in, in, ADDR_WIDTH: jump target.
- trap_enable_in, in, 1: trap request.
- trap_address_in, in, ADDR_WIDTH: trap target.
- stall_out, out, NUM_STAGES: hold mask.
- bubble_out, out, NUM_STAGES: one-hot NOP insert.
- flush_out, out, NUM_STAGES: flush mask.
- pc_load_out, out, 1: load new_pc_out into PC.
- new_pc_out, out, ADDR_WIDTH: redirect target.
- mc_busy_out, out, 1: multi-cycle counter nonzero.
- redirect_pending_out, out, 1: a redirect is held.
- stall_cycles_out, out, PERF_WIDTH: perf counter.

Behaviour:
- State registers:
  - mc_cnt (CNT_WIDTH)
  - pend_valid, pend_is_trap, pend_addr
  - perf counter
- Reset: all state cleared to 0. While reset_in=1, every output is 0.
- Effective request vector eff = stall_req_in, OR'ed with bits 0..MC_STAGE when mc_cnt≠0.
- Redirect selection, in priority order:
  1. Pending redirect.
  2. New trap.
  3. New jump.
  - The selected redirect has stage S (TRAP_STAGE or JUMP_STAGE).
  - It is blocked if any eff bit above S is set; otherwise it issues this cycle.
- Issue (combinational, same cycle):
  - pc_load_out=1 and new_pc_out = selected address.
  - flush_out bits 1..S = 1.
  - eff bits 0..S are masked off before stall_out is formed, because flushed instructions cannot stall.
  - pend_valid is cleared on the next edge.
  - A trap issue also clears mc_cnt.
- Blocked redirect: captured into pend_* on the clock edge. redirect_pending_out is 1 from the next cycle.
- Pending conflicts:
  - A new jump while pend_valid is set is ignored, since the held EX instruction re-asserts the same jump.
  - A new trap replaces a pending jump.
  - A trap arriving in the same cycle as a jump always wins; the jump is dropped.
- Stall vector: stall_out[k] = OR of masked eff[j] for j ≥ k.
- Bubble: with h = highest set bit of stall_out, bubble_out[h+1]=1 when h+1 < NUM_STAGES. No bubble when stall_out=0.
- Flush/stall overlap: where flush_out and stall_out overlap, flush wins on that boundary; the stall bit is forced to 0.
- Multi-cycle counter:
  - mc_start_in with mc_cycles_in=N≠0 loads N; mc_cnt then decrements each cycle.
  - Bits 0..MC_STAGE are stalled for exactly N cycles, starting the cycle after the start.
  - N=0 gives no stall.
  - mc_start_in while mc_cnt≠0 is ignored.
  - mc_start_in in the same cycle as a trap issue is ignored.
- Perf counter: increments when stall_out[0]=1 and saturates at all-ones.
- Reset mid-operation: pending redirect and counter are lost and no flush is emitted.

Decomposition:
- Shared core defines header provides:
  - STOP/NOSTOP
  - ADDR_WIDTH
  - Named stage indices: STG_PC=0, STG_IF_ID=1, STG_ID_EX=2, STG_EX_MEM=3, STG_MEM_WB=4.
- One natural sub-module: pipe_mc_counter, covering the load/decrement/busy counter with the abort input.

Test Plan:
- stall_req_in=6'b000100 for one cycle -> stall_out=6'b000111, bubble_out=6'b001000, no flush.
- jump_enable_in=1, jump_address_in=0x100, no stalls -> same cycle: pc_load_out=1, new_pc_out=0x100, flush_out=6'b000110.
- stall_req_in=6'b010000 for 3 cycles plus a jump to 0x200 -> stall_out=6'b011111 during those cycles and redirect_pending_out=1. In the first cycle with stall_req_in=0: pc_load_out=1, new_pc_out=0x200, flush_out=6'b000110.
- mc_start_in with N=4 -> mc_busy_out and stall_out=6'b001111 for exactly 4 cycles, then 0. A second start during this period has no effect.
- Trap to 0x80 and jump to 0x300 in the same cycle, with mc_cnt=3 -> new_pc_out=0x80, flush_out=6'b001110, mc_cnt cleared next cycle.
- Reset asserted while a redirect is pending and stall_out=6'b011111 -> all outputs 0 immediately. stall_cycles_out=0 after reset release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions for the pipeline hazard controller.
// Provides stall polarity constants, the default PC width, the named
// pipeline boundary indices and the redirect-source encoding.
package pipe_hazard_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int unsigned ADDR_WIDTH = 32;

  // Pipeline boundary indices, bit 0 is the PC, ascending downstream
  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IF_ID  = 1;
  localparam int unsigned STG_ID_EX  = 2;
  localparam int unsigned STG_EX_MEM = 3;
  localparam int unsigned STG_MEM_WB = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PEND = 2'd1,
    SRC_TRAP = 2'd2,
    SRC_JUMP = 2'd3
  } redir_src_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
// master: pipeline stages (drive requests, consume controls).
// slave : hazard controller (consume requests, drive controls).
//   stall_req_in / mc_start_in / mc_cycles_in  : stall and multi-cycle requests
//   jump_* / trap_*                            : redirect requests
//   stall_out / bubble_out / flush_out         : per-boundary controls
//   pc_load_out / new_pc_out                   : PC redirect
//   mc_busy_out / redirect_pending_out         : status
//   stall_cycles_out                           : stall perf counter
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6,
  parameter int unsigned PERF_WIDTH = 32
);

  logic [NUM_STAGES-1:0] stall_req_in;
  logic                  mc_start_in;
  logic [CNT_WIDTH-1:0]  mc_cycles_in;
  logic                  jump_enable_in;
  logic [ADDR_WIDTH-1:0] jump_address_in;
  logic                  trap_enable_in;
  logic [ADDR_WIDTH-1:0] trap_address_in;

  logic [NUM_STAGES-1:0] stall_out;
  logic [NUM_STAGES-1:0] bubble_out;
  logic [NUM_STAGES-1:0] flush_out;
  logic                  pc_load_out;
  logic [ADDR_WIDTH-1:0] new_pc_out;
  logic                  mc_busy_out;
  logic                  redirect_pending_out;
  logic [PERF_WIDTH-1:0] stall_cycles_out;

  modport master (
    output stall_req_in, mc_start_in, mc_cycles_in,
           jump_enable_in, jump_address_in, trap_enable_in, trap_address_in,
    input  stall_out, bubble_out, flush_out, pc_load_out, new_pc_out,
           mc_busy_out, redirect_pending_out, stall_cycles_out
  );

  modport slave (
    input  stall_req_in, mc_start_in, mc_cycles_in,
           jump_enable_in, jump_address_in, trap_enable_in, trap_address_in,
    output stall_out, bubble_out, flush_out, pc_load_out, new_pc_out,
           mc_busy_out, redirect_pending_out, stall_cycles_out
  );

endinterface

// File: rtl/pipe_mc_counter.sv
// Multi-cycle op down-counter.
//   clk_in, reset_in : clock, async active-high reset
//   start, cycles    : load request and extra stall cycle count
//   abort            : clears the count (trap issue), wins over start
//   busy             : count is nonzero
module pipe_mc_counter #(
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cycles,
  output logic                 busy
);

  logic [CNT_WIDTH-1:0] cnt;

  // A start while counting is ignored; loading zero yields no stall
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end else if (start) begin
      cnt <= cycles;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: merges stall requests into a thermometer hold
// mask, inserts a bubble below the highest held boundary, sequences
// multi-cycle stalls and arbitrates/holds trap and jump redirects.
//   clk_in, reset_in : clock, async active-high reset
//   bus (slave)      : requests in, stall/bubble/flush/PC controls out
// Controls are combinational from the current requests and forced to 0
// while reset is asserted.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned ADDR_WIDTH = pipe_hazard_ctrl_pkg::ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = 6,
  parameter int unsigned JUMP_STAGE = pipe_hazard_ctrl_pkg::STG_ID_EX,
  parameter int unsigned TRAP_STAGE = pipe_hazard_ctrl_pkg::STG_EX_MEM,
  parameter int unsigned MC_STAGE   = pipe_hazard_ctrl_pkg::STG_EX_MEM,
  parameter int unsigned PERF_WIDTH = 32
) (
  input logic               clk_in,
  input logic               reset_in,
  pipe_hazard_ctrl_if.slave bus
);

  import pipe_hazard_ctrl_pkg::*;

  logic                  pend_valid;
  logic                  pend_is_trap;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [PERF_WIDTH-1:0] perf;
  logic                  mc_busy;

  logic [NUM_STAGES-1:0] eff;
  logic [NUM_STAGES-1:0] masked;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] bubble;
  logic [NUM_STAGES-1:0] flush;
  redir_src_e            src;
  logic                  sel_trap;
  logic [ADDR_WIDTH-1:0] sel_addr;
  int unsigned           sel_stage;
  logic                  blocked;
  logic                  issue;
  logic                  acc;

  // Request merge, redirect arbitration, stall/bubble/flush forming
  always_comb begin
    eff       = bus.stall_req_in;
    src       = SRC_NONE;
    sel_trap  = 1'b0;
    sel_addr  = '0;
    sel_stage = JUMP_STAGE;
    blocked   = 1'b0;
    masked    = '0;
    flush     = '0;
    stall_raw = '0;
    bubble    = '0;
    acc       = 1'b0;

    for (int unsigned k = STG_PC; k < NUM_STAGES; k++) begin
      if (mc_busy && (k <= MC_STAGE)) eff[k] = STOP;
    end

    // Pending wins, except a new trap supersedes a pending jump; a new
    // jump under a pending redirect is the same jump re-asserted
    if (pend_valid && (pend_is_trap || !bus.trap_enable_in)) src = SRC_PEND;
    else if (bus.trap_enable_in)                             src = SRC_TRAP;
    else if (bus.jump_enable_in && !pend_valid)              src = SRC_JUMP;

    case (src)
      SRC_PEND: begin sel_trap = pend_is_trap; sel_addr = pend_addr;           end
      SRC_TRAP: begin sel_trap = 1'b1;         sel_addr = bus.trap_address_in; end
      SRC_JUMP: begin sel_trap = 1'b0;         sel_addr = bus.jump_address_in; end
      default:  begin sel_trap = 1'b0;         sel_addr = '0;                  end
    endcase
    sel_stage = sel_trap ? TRAP_STAGE : JUMP_STAGE;

    // Any hold request downstream of the owning stage blocks the redirect
    for (int unsigned k = STG_PC; k < NUM_STAGES; k++) begin
      if (k > sel_stage) blocked = blocked | eff[k];
    end
    issue = (src != SRC_NONE) && !blocked;

    // Flushed boundaries cannot request a stall
    masked = eff;
    for (int unsigned k = STG_PC; k < NUM_STAGES; k++) begin
      if (issue && (k <= sel_stage)) begin
        masked[k] = NOSTOP;
        if (k >= STG_IF_ID) flush[k] = 1'b1;
      end
    end

    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      acc          = acc | masked[k];
      stall_raw[k] = acc;
    end
    stall = stall_raw & ~flush;

    // Thermometer edge marks the boundary just below the held region
    for (int unsigned k = STG_IF_ID; k < NUM_STAGES; k++) begin
      bubble[k] = stall[k-1] & ~stall[k];
    end
  end

  pipe_mc_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_mc_counter (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .start    (bus.mc_start_in),
    .abort    (issue && sel_trap),
    .cycles   (bus.mc_cycles_in),
    .busy     (mc_busy)
  );

  // Pending redirect capture/clear
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
      pend_addr    <= '0;
    end else if (issue) begin
      pend_valid   <= 1'b0;
    end else if (src != SRC_NONE) begin
      pend_valid   <= 1'b1;
      pend_is_trap <= sel_trap;
      pend_addr    <= sel_addr;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      perf <= '0;
    end else if (stall[STG_PC] && (perf != '1)) begin
      perf <= perf + PERF_WIDTH'(1);
    end
  end

  assign bus.stall_out            = reset_in ? '0 : stall;
  assign bus.bubble_out           = reset_in ? '0 : bubble;
  assign bus.flush_out            = reset_in ? '0 : flush;
  assign bus.pc_load_out          = !reset_in && issue;
  assign bus.new_pc_out           = (!reset_in && issue) ? sel_addr : '0;
  assign bus.mc_busy_out          = mc_busy;
  assign bus.redirect_pending_out = pend_valid;
  assign bus.stall_cycles_out     = perf;

endmodule
